// File: rtl/pcie_str_rx_buffer.sv
// pcie_str_rx_buffer: host-to-user stream RX buffer with word counter and threshold interrupt.
// Latency 1 cycle push-to-valid, no bypass; backpressure: o_str_ack = ~full from registered fill level.
// Optional macro PCIE_STR_RX_BUFFER_STALL_CNT_EN adds o_stall_count (upstream stall cycles).

// pcie_str_rx_fifo: first-word-fall-through FIFO, 2^AW entries.
// Latency 1 cycle write-to-head; full/empty decoded from the registered level only.
// Caller must not push when full nor pop when empty.
module pcie_str_rx_fifo #(
    parameter int W  = 64,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
        end
    end

    // Storage is not reset; the head is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_dat;
    end

    assign level    = level_q;
    assign full     = (level_q == FULL_LVL);
    assign empty    = (level_q == '0);
    assign head_dat = empty ? '0 : mem[rd_ptr_q];
endmodule

module pcie_str_rx_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH_LOG2 = 9,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_pcie_clk,
    input  logic                  i_rst_n,
    input  logic                  i_str_data_valid,
    output logic                  o_str_ack,
    input  logic [DATA_WIDTH-1:0] i_str_data,
    output logic                  o_user_data_valid,
    input  logic                  i_user_ack,
    output logic [DATA_WIDTH-1:0] o_user_data,
    input  logic [CNT_WIDTH-1:0]  i_threshold,
    input  logic                  i_count_clr,
    output logic [CNT_WIDTH-1:0]  o_word_count,
    output logic [DEPTH_LOG2:0]   o_fill_level,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_intr_req,
`ifdef PCIE_STR_RX_BUFFER_STALL_CNT_EN
    output logic [31:0]           o_stall_count,
`endif
    input  logic                  i_intr_ack
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } intr_state_t;

    intr_state_t          state_q;
    intr_state_t          state_d;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 cnt_clr;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 intr_req;

    assign o_str_ack         = ~fifo_full;
    assign o_user_data_valid = ~fifo_empty;
    assign push              = i_str_data_valid & ~fifo_full;
    assign pop               = i_user_ack & ~fifo_empty;

    pcie_str_rx_fifo #(
        .W  (DATA_WIDTH),
        .AW (DEPTH_LOG2)
    ) u_fifo (
        .clk      (i_pcie_clk),
        .rst_n    (i_rst_n),
        .push     (push),
        .push_dat (i_str_data),
        .pop      (pop),
        .head_dat (o_user_data),
        .level    (o_fill_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign o_full  = fifo_full;
    assign o_empty = fifo_empty;

    // Acknowledging the interrupt re-arms by clearing the counter in the same cycle.
    always_comb begin
        cnt_clr = i_count_clr | ((state_q == ST_REQ) & i_intr_ack);
        cnt_d   = cnt_q;
        if (cnt_clr)
            cnt_d = push ? CNT_WIDTH'(1) : '0;
        else if (push && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_pcie_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Equality (not >=) so lowering the threshold under the count stays quiet until a clear.
    always_comb begin
        state_d  = state_q;
        intr_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((i_threshold != '0) && (cnt_d == i_threshold))
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                intr_req = 1'b1;
                if (i_intr_ack)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_intr_req   = intr_req;
    assign o_word_count = cnt_q;

`ifdef PCIE_STR_RX_BUFFER_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge i_pcie_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            stall_q <= '0;
        else if (i_count_clr)
            stall_q <= '0;
        else if (i_str_data_valid && fifo_full && (stall_q != '1))
            stall_q <= stall_q + 1'b1;
    end

    assign o_stall_count = stall_q;
`endif
endmodule

// File: tb/tb_pcie_str_rx_buffer.sv
// Randomized self-checking bench for pcie_str_rx_buffer against a queue/integer reference model.
module tb_pcie_str_rx_buffer;
    localparam int DEPTH = 512;

    logic        i_pcie_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_str_data_valid = 1'b0;
    logic        o_str_ack;
    logic [63:0] i_str_data = '0;
    logic        o_user_data_valid;
    logic        i_user_ack = 1'b0;
    logic [63:0] o_user_data;
    logic [31:0] i_threshold = '0;
    logic        i_count_clr = 1'b0;
    logic [31:0] o_word_count;
    logic [9:0]  o_fill_level;
    logic        o_full;
    logic        o_empty;
    logic        o_intr_req;
    logic        i_intr_ack = 1'b0;
`ifdef PCIE_STR_RX_BUFFER_STALL_CNT_EN
    logic [31:0] o_stall_count;
`endif

    int          n_tests = 0;
    int          n_fail = 0;
    logic [63:0] q[$];
    logic [31:0] m_cnt = '0;
    bit          m_intr = 1'b0;

    pcie_str_rx_buffer dut (
        .i_pcie_clk        (i_pcie_clk),
        .i_rst_n           (i_rst_n),
        .i_str_data_valid  (i_str_data_valid),
        .o_str_ack         (o_str_ack),
        .i_str_data        (i_str_data),
        .o_user_data_valid (o_user_data_valid),
        .i_user_ack        (i_user_ack),
        .o_user_data       (o_user_data),
        .i_threshold       (i_threshold),
        .i_count_clr       (i_count_clr),
        .o_word_count      (o_word_count),
        .o_fill_level      (o_fill_level),
        .o_full            (o_full),
        .o_empty           (o_empty),
        .o_intr_req        (o_intr_req),
`ifdef PCIE_STR_RX_BUFFER_STALL_CNT_EN
        .o_stall_count     (o_stall_count),
`endif
        .i_intr_ack        (i_intr_ack)
    );

    always #5 i_pcie_clk = ~i_pcie_clk;

    // Apply the current inputs to the reference model, then advance one clock and settle.
    task automatic step();
        bit push, pop, clr;
        push = i_str_data_valid && (q.size() < DEPTH);
        pop  = i_user_ack && (q.size() > 0);
        clr  = i_count_clr || (m_intr && i_intr_ack);
        if (pop) q.delete(0);
        if (push) q.push_back(i_str_data);
        if (clr) m_cnt = push ? 32'd1 : 32'd0;
        else if (push && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (m_intr) begin
            if (i_intr_ack) m_intr = 1'b0;
        end else if (i_threshold != 0 && m_cnt == i_threshold) begin
            m_intr = 1'b1;
        end
        @(posedge i_pcie_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_str_data_valid = 1'b0;
        i_user_ack = 1'b0;
        i_intr_ack = 1'b0;
        i_count_clr = 1'b0;
    endtask

    task automatic drain(string name);
        int guard;
        guard = 0;
        idle_inputs();
        i_user_ack = 1'b1;
        while (q.size() > 0 && guard < 700) begin
            n_tests++;
            if (o_user_data !== q[0]) begin n_fail++; $display("FAIL %s_drain got %h exp %h", name, o_user_data, q[0]); end
            step();
            guard++;
        end
        i_user_ack = 1'b0;
        n_tests++;
        if (o_empty !== 1'b1) begin n_fail++; $display("FAIL %s_drain_empty got %0b exp 1", name, o_empty); end
    endtask

    task automatic test_reset();
        idle_inputs();
        i_threshold = '0;
        i_rst_n = 1'b0;
        #3;
        n_tests++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %0b exp 1", o_empty); end
        n_tests++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %0b exp 0", o_full); end
        n_tests++; if (o_user_data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b exp 0", o_user_data_valid); end
        n_tests++; if (o_user_data !== 64'd0) begin n_fail++; $display("FAIL rst_data got %h exp 0", o_user_data); end
        @(negedge i_pcie_clk);
        i_rst_n = 1'b1;
        q.delete(); m_cnt = '0; m_intr = 1'b0;
        @(posedge i_pcie_clk); #1;
        n_tests++; if (o_str_ack !== 1'b1) begin n_fail++; $display("FAIL rel_ack got %0b exp 1", o_str_ack); end
        n_tests++; if (o_intr_req !== 1'b0) begin n_fail++; $display("FAIL rel_intr got %0b exp 0", o_intr_req); end
        n_tests++; if (o_word_count !== 32'd0) begin n_fail++; $display("FAIL rel_count got %0d exp 0", o_word_count); end
        n_tests++; if (o_fill_level !== 10'd0) begin n_fail++; $display("FAIL rel_fill got %0d exp 0", o_fill_level); end
    endtask

    task automatic test_basic();
        logic [63:0] base;
        base = 64'hA5A5_0000_0000_0000;
        for (int i = 1; i <= 3; i++) begin
            i_str_data_valid = 1'b1;
            i_str_data = base | 64'(i);
            step();
            if (i == 1) begin
                n_tests++; if (o_user_data_valid !== 1'b1) begin n_fail++; $display("FAIL basic_first_valid got %0b exp 1", o_user_data_valid); end
                n_tests++; if (o_user_data !== (base | 64'd1)) begin n_fail++; $display("FAIL basic_first_data got %h exp %h", o_user_data, base | 64'd1); end
            end
        end
        i_str_data_valid = 1'b0;
        n_tests++; if (o_fill_level !== 10'd3) begin n_fail++; $display("FAIL basic_fill got %0d exp 3", o_fill_level); end
        n_tests++; if (o_user_data !== (base | 64'd1)) begin n_fail++; $display("FAIL basic_hold got %h exp %h", o_user_data, base | 64'd1); end
        i_user_ack = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            n_tests++; if (o_user_data !== (base | 64'(i))) begin n_fail++; $display("FAIL basic_order got %h exp %h", o_user_data, base | 64'(i)); end
            step();
        end
        i_user_ack = 1'b0;
        n_tests++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %0b exp 1", o_empty); end
        n_tests++; if (o_word_count !== 32'd3) begin n_fail++; $display("FAIL basic_count got %0d exp 3", o_word_count); end
    endtask

    task automatic test_full();
        logic [63:0] w513;
`ifdef PCIE_STR_RX_BUFFER_STALL_CNT_EN
        logic [31:0] stall_before;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            i_str_data_valid = 1'b1;
            i_str_data = {$urandom, $urandom};
            step();
        end
        n_tests++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %0b exp 1", o_full); end
        n_tests++; if (o_str_ack !== 1'b0) begin n_fail++; $display("FAIL full_ack got %0b exp 0", o_str_ack); end
        n_tests++; if (o_fill_level !== 10'd512) begin n_fail++; $display("FAIL full_fill got %0d exp 512", o_fill_level); end
        w513 = {$urandom, $urandom};
        i_str_data = w513;
        i_user_ack = 1'b1;
        n_tests++; if (o_str_ack !== 1'b0) begin n_fail++; $display("FAIL full_pop_ack got %0b exp 0", o_str_ack); end
`ifdef PCIE_STR_RX_BUFFER_STALL_CNT_EN
        stall_before = o_stall_count;
`endif
        step();
`ifdef PCIE_STR_RX_BUFFER_STALL_CNT_EN
        n_tests++; if (o_stall_count !== stall_before + 32'd1) begin n_fail++; $display("FAIL stall_count got %0d exp %0d", o_stall_count, stall_before + 32'd1); end
`endif
        i_user_ack = 1'b0;
        n_tests++; if (o_str_ack !== 1'b1) begin n_fail++; $display("FAIL full_ack_rise got %0b exp 1", o_str_ack); end
        step();
        i_str_data_valid = 1'b0;
        n_tests++; if (o_fill_level !== 10'd512) begin n_fail++; $display("FAIL full_refill got %0d exp 512", o_fill_level); end
        n_tests++; if (q[q.size()-1] !== w513) begin n_fail++; $display("FAIL full_w513_model got %h exp %h", q[q.size()-1], w513); end
        drain("full");
    endtask

    task automatic test_wrap();
        int popped, cycles;
        popped = 0;
        cycles = 0;
        while (popped < 1024 && cycles < 8000) begin
            i_str_data_valid = ($urandom_range(0, 9) < 6);
            i_str_data = {$urandom, $urandom};
            i_user_ack = ($urandom_range(0, 1) == 1);
            n_tests++; if (o_fill_level !== 10'(q.size())) begin n_fail++; $display("FAIL wrap_fill got %0d exp %0d", o_fill_level, q.size()); end
            if (q.size() > 0) begin
                n_tests++; if (o_user_data !== q[0]) begin n_fail++; $display("FAIL wrap_data got %h exp %h", o_user_data, q[0]); end
                if (i_user_ack) popped++;
            end
            step();
            cycles++;
        end
        n_tests++; if (popped < 1024) begin n_fail++; $display("FAIL wrap_timeout got %0d exp 1024", popped); end
        drain("wrap");
    endtask

    task automatic test_intr();
        idle_inputs();
        i_count_clr = 1'b1;
        step();
        i_count_clr = 1'b0;
        i_threshold = 32'd4;
        for (int i = 0; i < 4; i++) begin
            i_str_data_valid = 1'b1;
            i_str_data = {$urandom, $urandom};
            step();
            if (i == 2) begin
                n_tests++; if (o_intr_req !== 1'b0) begin n_fail++; $display("FAIL intr_early got %0b exp 0", o_intr_req); end
            end
        end
        i_str_data_valid = 1'b0;
        n_tests++; if (o_intr_req !== 1'b1) begin n_fail++; $display("FAIL intr_raise got %0b exp 1", o_intr_req); end
        n_tests++; if (o_word_count !== 32'd4) begin n_fail++; $display("FAIL intr_count4 got %0d exp 4", o_word_count); end
        i_intr_ack = 1'b1;
        i_str_data_valid = 1'b1;
        i_str_data = {$urandom, $urandom};
        step();
        idle_inputs();
        n_tests++; if (o_intr_req !== 1'b0) begin n_fail++; $display("FAIL intr_ack_drop got %0b exp 0", o_intr_req); end
        n_tests++; if (o_word_count !== 32'd1) begin n_fail++; $display("FAIL intr_ack_count got %0d exp 1", o_word_count); end
        i_intr_ack = 1'b1;
        step();
        i_intr_ack = 1'b0;
        n_tests++; if (o_word_count !== 32'd1) begin n_fail++; $display("FAIL intr_idle_ack got %0d exp 1", o_word_count); end
        drain("intr");
    endtask

    task automatic test_thr_zero();
        idle_inputs();
        i_threshold = '0;
        i_count_clr = 1'b1;
        step();
        i_count_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            i_str_data_valid = 1'b1;
            i_str_data = {$urandom, $urandom};
            i_user_ack = ($urandom_range(0, 1) == 1);
            step();
            n_tests++; if (o_intr_req !== 1'b0) begin n_fail++; $display("FAIL thr0_intr got %0b exp 0", o_intr_req); end
        end
        idle_inputs();
        n_tests++; if (o_word_count !== 32'd10) begin n_fail++; $display("FAIL thr0_count got %0d exp 10", o_word_count); end
        drain("thr0");
    endtask

    task automatic test_random_intr();
        i_threshold = 32'($urandom_range(1, 6));
        for (int c = 0; c < 600; c++) begin
            i_str_data_valid = ($urandom_range(0, 9) < 7);
            i_str_data = {$urandom, $urandom};
            i_user_ack = ($urandom_range(0, 9) < 6);
            i_intr_ack = m_intr && ($urandom_range(0, 9) < 3);
            i_count_clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) == 0) i_threshold = 32'($urandom_range(0, 6));
            n_tests++; if (o_intr_req !== m_intr) begin n_fail++; $display("FAIL rnd_intr got %0b exp %0b", o_intr_req, m_intr); end
            n_tests++; if (o_word_count !== m_cnt) begin n_fail++; $display("FAIL rnd_count got %0d exp %0d", o_word_count, m_cnt); end
            if (q.size() > 0) begin
                n_tests++; if (o_user_data !== q[0]) begin n_fail++; $display("FAIL rnd_data got %h exp %h", o_user_data, q[0]); end
            end
            step();
        end
        drain("rnd");
    endtask

    task automatic test_reset_mid();
        logic [63:0] first;
        idle_inputs();
        i_threshold = '0;
        for (int i = 0; i < 7; i++) begin
            i_str_data_valid = 1'b1;
            i_str_data = {$urandom, $urandom};
            step();
        end
        i_str_data_valid = 1'b0;
        n_tests++; if (o_fill_level !== 10'd7) begin n_fail++; $display("FAIL mid_fill got %0d exp 7", o_fill_level); end
        #2;
        i_rst_n = 1'b0;
        #1;
        n_tests++; if (o_fill_level !== 10'd0) begin n_fail++; $display("FAIL mid_rst_fill got %0d exp 0", o_fill_level); end
        n_tests++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_empty got %0b exp 1", o_empty); end
        n_tests++; if (o_user_data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %0b exp 0", o_user_data_valid); end
        n_tests++; if (o_word_count !== 32'd0) begin n_fail++; $display("FAIL mid_rst_count got %0d exp 0", o_word_count); end
        n_tests++; if (o_intr_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_intr got %0b exp 0", o_intr_req); end
        n_tests++; if (o_user_data !== 64'd0) begin n_fail++; $display("FAIL mid_rst_data got %h exp 0", o_user_data); end
        @(negedge i_pcie_clk);
        i_rst_n = 1'b1;
        q.delete(); m_cnt = '0; m_intr = 1'b0;
        @(posedge i_pcie_clk); #1;
        first = {$urandom, $urandom};
        i_str_data_valid = 1'b1;
        i_str_data = first;
        step();
        i_str_data_valid = 1'b0;
        n_tests++; if (o_user_data !== first) begin n_fail++; $display("FAIL mid_first_word got %h exp %h", o_user_data, first); end
        n_tests++; if (o_fill_level !== 10'd1) begin n_fail++; $display("FAIL mid_after_fill got %0d exp 1", o_fill_level); end
        drain("mid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_intr();
        test_thr_zero();
        test_random_intr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
